// File: rtl/la_cdc_pkg.sv
// Shared encodings and helpers for the req/ack clock-domain-crossing transmitter.
package la_cdc_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam logic PROTO_4PHASE = 1'b0;
  localparam logic PROTO_2PHASE = 1'b1;

  localparam int TO_W = 16;

  // A zero limit means the timeout is switched off.
  function automatic logic to_expired(input logic [TO_W-1:0] cnt, input logic [TO_W-1:0] limit);
    return (limit != {TO_W{1'b0}}) && (cnt == (limit - {{(TO_W-1){1'b0}}, 1'b1}));
  endfunction

endpackage

// File: rtl/la_cdc_acksync.sv
// Reset-to-zero flop chain bringing the destination acknowledge into the source clock.
module la_cdc_acksync
  import la_cdc_pkg::*;
#(
  parameter     PROP   = "DEFAULT",
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic nreset,
  input  logic ack,
  output logic ack_s
);

  logic [STAGES-1:0] sync_r;

  if (PROP == "DEFAULT") begin : g_generic
    // Generic flop chain.
    always_ff @(posedge clk) begin
      if (!nreset) sync_r <= {STAGES{1'b0}};
      else         sync_r <= {sync_r[STAGES-2:0], ack};
    end
  end else begin : g_target
    // Slot for target-specific synchronizer cells; behaves as the generic chain.
    always_ff @(posedge clk) begin
      if (!nreset) sync_r <= {STAGES{1'b0}};
      else         sync_r <= {sync_r[STAGES-2:0], ack};
    end
  end

  assign ack_s = sync_r[STAGES-1];

endmodule

// File: rtl/la_cdc_txhs.sv
// Source-side transmitter of a req/ack CDC handshake: accepts a word, holds it on
// cdc_data and signals it with cdc_req until the synchronized acknowledge completes it.
module la_cdc_txhs
  import la_cdc_pkg::*;
#(
  parameter     PROP     = "DEFAULT",
  parameter int DW       = 8,
  parameter int STAGES   = 2,
  parameter     PROTOCOL = "4PHASE",
  parameter int TIMEOUT  = 0
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          cdc_req,
  output logic [DW-1:0] cdc_data,
  input  logic          cdc_ack,
  output logic          busy,
  output logic          err,
  input  logic          err_clr
);

  localparam logic            PROTO_SEL = (PROTOCOL == "2PHASE") ? PROTO_2PHASE : PROTO_4PHASE;
  localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT);

  logic [1:0]      state_r;
  logic [1:0]      state_nxt_s;
  logic            ack_s;
  logic            accept_s;
  logic            load_s;
  logic            req_nxt_s;
  logic            to_hit_s;
  logic [TO_W-1:0] to_cnt_r;

  la_cdc_acksync #(
    .PROP   (PROP),
    .STAGES (STAGES)
  ) u_acksync (
    .clk    (clk),
    .nreset (nreset),
    .ack    (cdc_ack),
    .ack_s  (ack_s)
  );

  // A stale ack left over from a reset blocks new requests until it returns to cdc_req.
  assign in_ready = (state_r == ST_IDLE) & (ack_s == cdc_req) & nreset;
  assign accept_s = in_valid & in_ready;
  assign to_hit_s = to_expired(to_cnt_r, TO_LIMIT) && (state_r != ST_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!nreset) state_r <= ST_IDLE;
    else         state_r <= state_nxt_s;
  end

  // Next-state decode for both protocol flavours.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_REQ;
        else          state_nxt_s = ST_IDLE;
      end
      ST_REQ: begin
        if (PROTO_SEL == PROTO_2PHASE) begin
          if (ack_s == cdc_req) state_nxt_s = ST_IDLE;
          else                  state_nxt_s = ST_REQ;
        end else if (ack_s) begin
          state_nxt_s = ST_RELEASE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_RELEASE: begin
        if (!ack_s) state_nxt_s = ST_IDLE;
        else        state_nxt_s = ST_RELEASE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode: request level and data load strobe.
  always_comb begin
    load_s    = 1'b0;
    req_nxt_s = cdc_req;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          load_s    = 1'b1;
          req_nxt_s = (PROTO_SEL == PROTO_2PHASE) ? ~cdc_req : 1'b1;
        end else begin
          req_nxt_s = cdc_req;
        end
      end
      ST_REQ: begin
        if ((PROTO_SEL == PROTO_4PHASE) && ack_s) req_nxt_s = 1'b0;
        else                                      req_nxt_s = cdc_req;
      end
      ST_RELEASE: req_nxt_s = cdc_req;
      default:    req_nxt_s = 1'b0;
    endcase
  end

  // Registered request, held data and busy flag.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      cdc_req  <= 1'b0;
      cdc_data <= {DW{1'b0}};
      busy     <= 1'b0;
    end else begin
      cdc_req <= req_nxt_s;
      busy    <= (state_nxt_s != ST_IDLE);
      if (load_s) cdc_data <= in_data;
    end
  end

  // Wait counter: restarts on every state change and saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (!nreset)                                               to_cnt_r <= {TO_W{1'b0}};
    else if ((state_nxt_s != state_r) || (state_r == ST_IDLE)) to_cnt_r <= {TO_W{1'b0}};
    else if (to_cnt_r != {TO_W{1'b1}})                         to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
    else                                                       to_cnt_r <= to_cnt_r;
  end

  // Sticky timeout flag; a timeout in the same cycle as err_clr keeps it set.
  always_ff @(posedge clk) begin
    if (!nreset)       err <= 1'b0;
    else if (to_hit_s) err <= 1'b1;
    else if (err_clr)  err <= 1'b0;
    else               err <= err;
  end

endmodule
